// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target: register map, CONTROL/STATUS
// bit positions, serializer state encoding and the WLEN decode rule.
package spi_target_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_FILL    = 2'd3;

  localparam int CTRL_CPOL = 5;
  localparam int CTRL_CPHA = 6;
  localparam int CTRL_EN   = 7;

  localparam int ST_RXFO  = 0;
  localparam int ST_RXFF  = 1;
  localparam int ST_RXFE  = 2;
  localparam int ST_TXFO  = 3;
  localparam int ST_TXFF  = 4;
  localparam int ST_TXFE  = 5;
  localparam int ST_TXUR  = 6;
  localparam int ST_BUSY  = 7;
  localparam int ST_ABORT = 8;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  // A WLEN field of zero encodes a full 32-bit word.
  function automatic logic [5:0] word_bits(input logic [4:0] wlen);
    return (wlen == 5'd0) ? 6'd32 : {1'b0, wlen};
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// Avalon-MM register port of the SPI target. The host owns all strobes; the
// target only returns readdata, so master/slave differ only in direction.
interface spi_target_if;
  // Strobe semantics: an access happens in a cycle where chipselect and read
  // (or write) are high; there is no wait-request, every access completes in
  // that cycle and readdata is valid combinationally during it.
  logic        chipselect;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/spi_target_sync_fifo.sv
// Single-clock FIFO with head-of-queue output; pushes to a full FIFO are
// dropped and flagged by a one-cycle overflow pulse.
module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign overflow = push && full;
  assign dout     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples SCLK/MOSI/CS_n in the clk domain and exchanges
// configurable-width words with software through TX/RX FIFOs on an Avalon-MM port.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_target_if.slave bus,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  output state_t      dbg_state
);
  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
  logic sclk_d, cs_d, sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_fall, lead_edge, trail_edge, sample_edge, shift_edge;

  // Synchronizers are left unreset so a frame already in progress at reset
  // produces no false chip-select edge afterwards.
  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
    mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
    sclk_d <= sclk_s;
    cs_d   <= cs_s;
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];

  logic [7:0]        ctrl;
  logic [DATA_W-1:0] fill;
  logic [5:0]        wlen_bits;
  logic              cpol, cpha, enable;

  assign wlen_bits   = word_bits(ctrl[4:0]);
  assign cpol        = ctrl[CTRL_CPOL];
  assign cpha        = ctrl[CTRL_CPHA];
  assign enable      = ctrl[CTRL_EN];
  assign sclk_rise   = sclk_s && !sclk_d;
  assign sclk_fall   = !sclk_s && sclk_d;
  assign cs_fall     = !cs_s && cs_d;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  logic              rd, wr, live;
  logic              tx_push, tx_pop, tx_full, tx_empty, tx_ovf;
  logic              rx_push, rx_pop, rx_full, rx_empty, rx_ovf;
  logic [DATA_W-1:0] tx_dout, rx_dout, rx_din, load_word, aligned;

  assign rd      = bus.read && bus.chipselect;
  assign wr      = bus.write && bus.chipselect;
  assign tx_push = wr && (bus.address == ADDR_DATA);
  assign rx_pop  = rd && (bus.address == ADDR_DATA);

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus.writedata),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .overflow(tx_ovf)
  );

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_din),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .overflow(rx_ovf)
  );

  state_t            state, state_n;
  logic [4:0]        bit_idx;
  logic              got_bit, load_go, txur_set, abort_set, miso_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;

  assign live      = !cs_s && enable;
  assign load_word = tx_empty ? fill : tx_dout;
  // Left-align the outgoing word so its MSB always sits at the top of tx_sh.
  assign aligned   = load_word << (DATA_W - int'(wlen_bits));
  assign rx_din    = {rx_sh[DATA_W-2:0], mosi_s};

  always_comb begin
    state_n   = state;
    load_go   = 1'b0;
    tx_pop    = 1'b0;
    txur_set  = 1'b0;
    rx_push   = 1'b0;
    abort_set = 1'b0;
    case (state)
      IDLE:  if (cs_fall && enable) state_n = LOAD;
      LOAD: begin
        state_n  = SHIFT;
        load_go  = live;
        tx_pop   = live && !tx_empty;
        txur_set = live && tx_empty;
      end
      SHIFT: if (live && sample_edge && bit_idx == 5'd0) begin
        state_n = LOAD;
        rx_push = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !live) state_n = IDLE;
    abort_set = (state == SHIFT) && got_bit && cs_s && enable;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      got_bit <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      miso_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (load_go) begin
        bit_idx <= 5'(wlen_bits - 6'd1);
        got_bit <= 1'b0;
        rx_sh   <= '0;
        if (!cpha) begin
          miso_q <= aligned[DATA_W-1];
          tx_sh  <= aligned << 1;
        end else begin
          tx_sh  <= aligned;
        end
      end else if (state == SHIFT && live) begin
        if (sample_edge) begin
          rx_sh   <= rx_din;
          got_bit <= 1'b1;
          bit_idx <= bit_idx - 5'd1;
        end
        // In CPHA=0 the trailing edge of a word's last bit lands after the next
        // word's MSB is already out, so only shift once this word has sampled.
        if (shift_edge && (cpha || got_bit)) begin
          miso_q <= tx_sh[DATA_W-1];
          tx_sh  <= tx_sh << 1;
        end
      end
    end
  end

  logic rxfo, txfo, txur, abort_f, clr;
  assign clr = wr && (bus.address == ADDR_STATUS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl    <= '0;
      fill    <= '0;
      rxfo    <= 1'b0;
      txfo    <= 1'b0;
      txur    <= 1'b0;
      abort_f <= 1'b0;
    end else begin
      if (wr && bus.address == ADDR_CONTROL) ctrl <= bus.writedata[7:0];
      if (wr && bus.address == ADDR_FILL)    fill <= bus.writedata;
      rxfo    <= (rxfo    && !(clr && bus.writedata[ST_RXFO]))  || rx_ovf;
      txfo    <= (txfo    && !(clr && bus.writedata[ST_TXFO]))  || tx_ovf;
      txur    <= (txur    && !(clr && bus.writedata[ST_TXUR]))  || txur_set;
      abort_f <= (abort_f && !(clr && bus.writedata[ST_ABORT])) || abort_set;
    end
  end

  logic [31:0] status;
  always_comb begin
    status           = '0;
    status[ST_RXFO]  = rxfo;
    status[ST_RXFF]  = rx_full;
    status[ST_RXFE]  = rx_empty;
    status[ST_TXFO]  = txfo;
    status[ST_TXFF]  = tx_full;
    status[ST_TXFE]  = tx_empty;
    status[ST_TXUR]  = txur;
    status[ST_BUSY]  = (state != IDLE);
    status[ST_ABORT] = abort_f;
  end

  always_comb begin
    bus.readdata = '0;
    if (rd) begin
      case (bus.address)
        ADDR_DATA:    bus.readdata = rx_empty ? '0 : rx_dout;
        ADDR_STATUS:  bus.readdata = status;
        ADDR_CONTROL: bus.readdata = {24'd0, ctrl};
        default:      bus.readdata = fill;
      endcase
    end
  end

  assign miso_oe   = (state != IDLE);
  assign miso      = miso_oe && miso_q;
  assign dbg_state = state;

  logic unused_byteenable;
  assign unused_byteenable = ^bus.byteenable;
endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral) endpoint with an Avalon-MM register interface, the receiving end of the `spi` controller block. It samples an externally driven SCLK/MOSI/CS_n in the system `clk` domain, shifts configurable-width words in both directions, and buffers them in 16-entry TX and RX FIFOs that software accesses through a 4-word aperture. It sits on the same Avalon bus as `spi` and lets the FPGA act as an SPI peripheral, or act as a loopback partner for `spi` in system test.

## Interface
- `FIFO_DEPTH`, 16: entries per FIFO (power of 2).
- `DATA_W`, 32: word width; maximum shift length.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `mosi`, `cs_n`.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `chipselect`, `read`, `write` in 1: Avalon-MM strobes; `read` is high for exactly one cycle per access.
- `address` in 2: 0 DATA, 1 STATUS, 2 CONTROL, 3 FILL.
- `byteenable` in 4: ignored; all accesses are full-word.
- `writedata` in 32, `readdata` out 32: bus data. `readdata` is combinational and is 0 when `read && chipselect` is low.
- `sclk`, `mosi`, `cs_n` in 1: asynchronous SPI inputs.
- `miso` out 1, `miso_oe` out 1: serial output and its tristate enable.

## Operation
- CONTROL: [4:0] WLEN (bits per word; 0 = 32); [5] CPOL; [6] CPHA; [7] ENABLE. Reset value 0.
- FILL: word shifted out when the TX FIFO is empty at word start. Reset value 0.
- DATA write: push `writedata` to the TX FIFO. When full, drop the word and set TXFO.
- DATA read: `readdata` = RX head, then pop. When empty, return 0 and leave the pointers unchanged.
- STATUS: [0] RXFO W1C, [1] RXFF, [2] RXFE, [3] TXFO W1C, [4] TXFF, [5] TXFE, [6] TXUR W1C (word started on FILL), [7] BUSY (frame active), [8] ABORT W1C (CS_n rose mid-word).
- W1C rules: a write of 1 clears the bit. When a set event and a clear occur in the same cycle, the set wins.
- Frame: active while synchronized `cs_n` = 0 and ENABLE = 1.
  - `miso_oe` = frame active.
  - `miso` = 0 when idle.
- States:
  - IDLE → LOAD on the `cs_n` falling edge with ENABLE set.
  - LOAD → SHIFT.
  - SHIFT → LOAD after WLEN samples, pushing the RX word.
  - Any state → IDLE on a `cs_n` rise or when ENABLE is cleared.
- LOAD: pop the TX head into the shift-out register, or load FILL and set TXUR. Reset the bit index to WLEN−1.
- Edge definitions:
  - Leading edge = SCLK rising if CPOL = 0, falling if CPOL = 1.
  - CPHA = 0: sample on leading edges, update `miso` on trailing edges. `miso` presents the MSB as soon as LOAD completes.
  - CPHA = 1: update `miso` on leading edges (the first leading edge presents the MSB), sample on trailing edges.
- Bit order is MSB first.
- RX words are zero-extended to 32 bits. Pushing to a full RX FIFO drops the word and sets RXFO.
- Frames may contain any number of back-to-back words.
- When `cs_n` rises with a partial word:
  - Discard the partial RX bits.
  - Do not return the popped TX word to the FIFO.
  - Set ABORT. ABORT is not set when ENABLE is cleared mid-word.
- Same-cycle host pop and serializer push (or push and pop) on the same FIFO both take effect; the count is unchanged.

## Timing
- SPI input latency: SYNC_STAGES + 1 `clk` from pin to detected edge.
- `miso` update: 1 `clk` after the detected shift edge.
- RX push and RXFE deassertion: 1 `clk` after the final sample edge is detected.
- Constraints on the SPI side:
  - SCLK high and low times ≥ SYNC_STAGES + 2 `clk` each.
  - `cs_n` low to first SCLK edge ≥ SYNC_STAGES + 3 `clk`.
- After `reset` is asserted, at the next edge:
  - FIFOs are empty and all flags are cleared.
  - State = IDLE.
  - `miso`, `miso_oe` and `readdata` = 0.
- This holds when reset arrives mid-frame. A frame already in progress is ignored until `cs_n` next falls.

## Structure
- Package `spi_target_pkg` holds:
  - register addresses;
  - CONTROL/STATUS bit positions;
  - the state enum `{IDLE, LOAD, SHIFT}`;
  - the default WLEN-0 = 32 rule.
- Sub-module `sync_fifo` (parameters DATA_W, FIFO_DEPTH) provides:
  - ports push, pop, din, dout (head), full, empty, overflow set pulse;
  - two instances, TX and RX.
- The synchronizers, edge detection, bit counter and shift registers live in `spi_target`.

## Test plan
- CPOL = 0, CPHA = 0, WLEN = 8; TX push 0xA5; master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; DATA read = 0x0000003C; RXFE = 1 afterwards.
- All four CPOL/CPHA modes, WLEN = 0 (32 bits): TX 0xDEADBEEF / MOSI 0x12345678 exchanged exactly in each mode.
- Two-word frame with the TX FIFO empty and FILL = 0x55 (WLEN = 8) → MISO carries 0x55 twice; TXUR = 1; writing 0x40 to STATUS clears it.
- 17 RX words with no host reads → 16 stored, RXFO = 1, RXFF = 1; W1C 0x1 clears RXFO while RXFF stays 1.
- `cs_n` rises after 5 of 8 bits → RX FIFO unchanged, ABORT = 1; the next frame transfers correctly.
- Assert `reset` mid-word → next cycle `miso_oe` = 0, STATUS = 0x24 (RXFE, TXFE); a following frame works.
